// File: rtl/axil_wr_router_if.sv
// ============================================================================
// axil_wr_router_if : bus bundle for the AXI-Lite write router (master side,
//                     decoder and per-slave ports).  Revision: 1.0
// ============================================================================
`default_nettype none

interface axil_wr_router_if #(
  parameter int M          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVE_ID_W = (M > 1) ? $clog2(M) : 1
);
  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic [2:0]              s_awprot;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;

  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic [SLAVE_ID_W-1:0]   dec_slave_id;
  logic                    dec_decerr;

  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [2:0]              m_awprot;
  logic [M-1:0]            m_awvalid;
  logic [M-1:0]            m_awready;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic [M-1:0]            m_wvalid;
  logic [M-1:0]            m_wready;
  logic [2*M-1:0]          m_bresp;
  logic [M-1:0]            m_bvalid;
  logic [M-1:0]            m_bready;

  // The router itself
  modport slave (
    input  s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output dec_addr,
    input  dec_slave_id, dec_decerr,
    output m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  // Everything around the router: upstream master, decoder and slaves
  modport master (
    output s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  dec_addr,
    output dec_slave_id, dec_decerr,
    input  m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

`default_nettype wire

// File: rtl/axil_wr_router.sv
// ============================================================================
// axil_wr_router : single-master to M-slave AXI-Lite write router, one write
//                  in flight. Optional macro AXIL_WR_DECERR_CNT_EN adds
//                  decerr_count.  Revision: 1.0
// ============================================================================
`default_nettype none

module axil_wr_router #(
  parameter int M          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVE_ID_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef AXIL_WR_DECERR_CNT_EN
  output logic [15:0]       decerr_count,
`endif
  axil_wr_router_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ROUTE  = 3'd2,
    WAIT_B = 3'd3,
    ERR_W  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;
  logic [SLAVE_ID_W-1:0] sel_q, sel_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [1:0]            bresp_q, bresp_d;

  logic [M-1:0]          sel_oh;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  dec_id_bad;

  assign sel_oh     = M'(1) << sel_q;
  assign aw_hs      = (state_q == ROUTE) && !aw_done_q && bus.m_awready[sel_q];
  assign w_hs       = (state_q == ROUTE) && !w_done_q && bus.s_wvalid && bus.m_wready[sel_q];
  // An index past the last port is treated like an unmapped address
  assign dec_id_bad = int'(bus.dec_slave_id) >= M;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    sel_d     = sel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bresp_d   = bresp_q;
    case (state_q)
      IDLE: begin
        if (bus.s_awvalid) begin
          addr_d  = bus.s_awaddr;
          prot_d  = bus.s_awprot;
          state_d = DECODE;
        end
      end
      DECODE: begin
        sel_d   = bus.dec_slave_id;
        state_d = (bus.dec_decerr || dec_id_bad) ? ERR_W : ROUTE;
      end
      ROUTE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.m_bvalid[sel_q]) begin
          bresp_d = bus.m_bresp[2*sel_q +: 2];
          state_d = RESP;
        end
      end
      ERR_W: begin
        if (bus.s_wvalid) begin
          bresp_d = 2'b11;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.s_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      prot_q    <= '0;
      sel_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bus.s_awready = (state_q == IDLE);
  assign bus.s_wready  = ((state_q == ROUTE) && !w_done_q && bus.m_wready[sel_q]) ||
                         (state_q == ERR_W);
  assign bus.s_bvalid  = (state_q == RESP);
  assign bus.s_bresp   = bresp_q;

  assign bus.dec_addr  = addr_q;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awprot  = prot_q;
  assign bus.m_awvalid = ((state_q == ROUTE) && !aw_done_q) ? sel_oh : '0;
  // W is a combinational pass-through, zeroed outside ROUTE so reset shows zeros
  assign bus.m_wvalid  = ((state_q == ROUTE) && !w_done_q && bus.s_wvalid) ? sel_oh : '0;
  assign bus.m_wdata   = (state_q == ROUTE) ? bus.s_wdata : '0;
  assign bus.m_wstrb   = (state_q == ROUTE) ? bus.s_wstrb : '0;
  assign bus.m_bready  = (state_q == WAIT_B) ? sel_oh : '0;

`ifdef AXIL_WR_DECERR_CNT_EN
  logic [15:0] decerr_count_q, decerr_count_d;

  always_comb begin
    decerr_count_d = decerr_count_q;
    if ((state_q == ERR_W) && bus.s_wvalid && (decerr_count_q != 16'hFFFF))
      decerr_count_d = decerr_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) decerr_count_q <= '0;
    else     decerr_count_q <= decerr_count_d;
  end

  assign decerr_count = decerr_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axil_wr_router.sv
// ============================================================================
// tb_axil_wr_router : directed self-checking bench for axil_wr_router.
//                     Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axil_wr_router;
  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  axil_wr_router_if #(.M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_ID_W(SW)) bus ();

`ifdef AXIL_WR_DECERR_CNT_EN
  logic [15:0] decerr_count;
`endif

  axil_wr_router #(.M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_ID_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef AXIL_WR_DECERR_CNT_EN
    .decerr_count (decerr_count),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Address map: 0x0000-0x3FFF, one 4 KiB window per slave; anything else unmapped
  always_comb begin
    bus.dec_decerr   = (bus.dec_addr[31:14] != '0);
    bus.dec_slave_id = bus.dec_addr[13:12];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model configuration
  int         cfg_aw_dly = 0;
  int         cfg_b_dly  = 0;
  logic [1:0] cfg_bresp  = 2'b00;
  int         s_aw_cnt   = 0;
  int         s_b_cnt    = 0;

  initial begin
    bus.m_awready = '0;
    bus.m_wready  = '1;
    bus.m_bvalid  = '0;
    bus.m_bresp   = '0;
    forever begin
      @(negedge clk);
      if (bus.m_awvalid != '0) begin
        s_aw_cnt++;
        bus.m_awready = (s_aw_cnt > cfg_aw_dly) ? bus.m_awvalid : '0;
      end else begin
        s_aw_cnt      = 0;
        bus.m_awready = '0;
      end
      if (bus.m_bready != '0) begin
        s_b_cnt++;
        if (s_b_cnt > cfg_b_dly) begin
          bus.m_bvalid = bus.m_bready;
          // Non-selected slaves present a decoy response
          for (int i = 0; i < M; i++)
            bus.m_bresp[2*i +: 2] = bus.m_bready[i] ? cfg_bresp : ~cfg_bresp;
        end
      end else begin
        s_b_cnt      = 0;
        bus.m_bvalid = '0;
      end
    end
  end

  // Monitor: sampled just after the falling edge, when inputs have settled
  int          txn_id  = 0;
  int          seen_id = 0;
  logic [M-1:0] exp_mask = '0;
  int          awv_cyc, awhs_cyc, whs_cyc, w_beats, swr_cycles, mon_viol;
  logic [M-1:0] aw_val_seen, w_oh_seen;
  logic [31:0] aw_addr_seen, w_data_seen;
  logic [3:0]  w_strb_seen;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (txn_id != seen_id) begin
        seen_id      = txn_id;
        awv_cyc      = -1;
        awhs_cyc     = -1;
        whs_cyc      = -1;
        w_beats      = 0;
        swr_cycles   = 0;
        mon_viol     = 0;
        aw_val_seen  = '0;
        w_oh_seen    = '0;
        aw_addr_seen = '0;
        w_data_seen  = '0;
        w_strb_seen  = '0;
      end
      if (((bus.m_awvalid | bus.m_wvalid | bus.m_bready) & ~exp_mask) != '0) mon_viol++;
      if ($countones(bus.m_awvalid) > 1) mon_viol++;
      if (bus.m_awvalid != '0 && awv_cyc < 0) begin
        awv_cyc      = cyc;
        aw_val_seen  = bus.m_awvalid;
        aw_addr_seen = bus.m_awaddr;
      end
      if ((bus.m_awvalid & bus.m_awready) != '0) awhs_cyc = cyc;
      if ((bus.m_wvalid & bus.m_wready) != '0) begin
        w_beats++;
        whs_cyc     = cyc;
        w_data_seen = bus.m_wdata;
        w_strb_seen = bus.m_wstrb;
        w_oh_seen   = bus.m_wvalid;
      end
      if (bus.s_wready) swr_cycles++;
    end
  end

  int   g_hs_cyc;
  int   g_stab_bad;
  logic g_aw_after;
  int   n_wait;

  // Called at a falling edge; returns at a falling edge after the W beat
  task automatic start_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    int n;
    bus.s_awaddr  = addr;
    bus.s_awprot  = 3'b010;
    bus.s_awvalid = 1'b1;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_wvalid  = 1'b1;
    n = 0;
    while (!bus.s_awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept_in_time", 64'(n < 50), 1);
    g_hs_cyc = cyc;
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    n = 0;
    while (!bus.s_wready && n < 50) begin @(negedge clk); n++; end
    chk("w_accept_in_time", 64'(n < 50), 1);
    @(negedge clk);
    bus.s_wvalid = 1'b0;
  endtask

  task automatic finish_write(input int bready_dly, output logic [1:0] resp);
    int n;
    logic [1:0] r0;
    n = 0;
    while (!bus.s_bvalid && n < 100) begin @(negedge clk); n++; end
    chk("b_in_time", 64'(n < 100), 1);
    r0 = bus.s_bresp;
    g_stab_bad = 0;
    for (int i = 0; i < bready_dly; i++) begin
      if (!bus.s_bvalid || bus.s_bresp != r0 || bus.s_awready) g_stab_bad++;
      @(negedge clk);
    end
    if (!bus.s_bvalid || bus.s_bresp != r0) g_stab_bad++;
    resp = bus.s_bresp;
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    g_aw_after   = bus.s_awready;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [M-1:0] mask,
                          input int aw_dly, input int b_dly, input logic [1:0] bresp,
                          input int bready_dly, output logic [1:0] resp);
    exp_mask   = mask;
    cfg_aw_dly = aw_dly;
    cfg_b_dly  = b_dly;
    cfg_bresp  = bresp;
    txn_id++;
    start_write(addr, data, strb);
    finish_write(bready_dly, resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    rst           = 1'b1;
    bus.s_awaddr  = '0;
    bus.s_awprot  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_master_side", {bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp}, 5'b10000);
    chk("rst_slave_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_bready}, '0);
    chk("rst_addr", {bus.dec_addr, bus.m_awaddr}, '0);
    chk("rst_wpayload", {bus.m_awprot, bus.m_wdata, bus.m_wstrb}, '0);
`ifdef AXIL_WR_DECERR_CNT_EN
    chk("rst_decerr_count", decerr_count, 16'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Mapped write to slave 2
    do_write(32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 4'b0100, 0, 0, 2'b00, 0, resp);
    chk("s2_aw_latency", 64'(awv_cyc - g_hs_cyc), 2);
    chk("s2_awvalid", aw_val_seen, 4'b0100);
    chk("s2_awaddr", aw_addr_seen, 32'h0000_2004);
    chk("s2_wdata", w_data_seen, 32'hDEAD_BEEF);
    chk("s2_wstrb", w_strb_seen, 4'hF);
    chk("s2_wvalid", w_oh_seen, 4'b0100);
    chk("s2_bresp", resp, 2'b00);
    chk("s2_no_stray", mon_viol, 0);

    // Unmapped write terminated locally
    do_write(32'h0000_5000, 32'h0BAD_F00D, 4'h3, 4'b0000, 0, 0, 2'b00, 0, resp);
    chk("err_no_awvalid", awv_cyc, -1);
    chk("err_no_wbeat", w_beats, 0);
    chk("err_wready_once", swr_cycles, 1);
    chk("err_bresp", resp, 2'b11);
    chk("err_no_stray", mon_viol, 0);
`ifdef AXIL_WR_DECERR_CNT_EN
    chk("err_decerr_count", decerr_count, 16'd1);
`endif

    // Slave 1: W three cycles ahead of AW, delayed SLVERR response
    do_write(32'h0000_1000, 32'h1111_2222, 4'hC, 4'b0010, 3, 5, 2'b10, 0, resp);
    chk("s1_w_before_aw", 64'(awhs_cyc - whs_cyc), 3);
    chk("s1_wready_once", swr_cycles, 1);
    chk("s1_wvalid", w_oh_seen, 4'b0010);
    chk("s1_bresp", resp, 2'b10);
    chk("s1_no_stray", mon_viol, 0);

    // Master stalls B for 4 cycles
    do_write(32'h0000_0020, 32'hCAFE_0001, 4'h1, 4'b0001, 0, 1, 2'b01, 4, resp);
    chk("stall_b_stable", g_stab_bad, 0);
    chk("stall_awready_after", g_aw_after, 1'b1);
    chk("stall_bresp", resp, 2'b01);

    // Reset while waiting for slave 3's B
    exp_mask   = 4'b1000;
    cfg_aw_dly = 0;
    cfg_b_dly  = 30;
    cfg_bresp  = 2'b00;
    txn_id++;
    start_write(32'h0000_3010, 32'h1234_5678, 4'h3);
    n_wait = 0;
    while (bus.m_bready == '0 && n_wait < 20) begin @(negedge clk); n_wait++; end
    chk("waitb_bready", bus.m_bready, 4'b1000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_master", {bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp}, 5'b10000);
    chk("async_rst_slave", {bus.m_awvalid, bus.m_wvalid, bus.m_bready}, '0);
    chk("async_rst_addr", {bus.dec_addr, bus.m_awaddr}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_bvalid", bus.s_bvalid, 1'b0);
    do_write(32'h0000_0010, 32'h5555_AAAA, 4'hF, 4'b0001, 0, 0, 2'b00, 0, resp);
    chk("post_rst_wdata", w_data_seen, 32'h5555_AAAA);
    chk("post_rst_bresp", resp, 2'b00);

    // Back-to-back: slave 0 then slave 3, distinguishable responses
    do_write(32'h0000_0100, 32'hA0A0_A0A0, 4'hF, 4'b0001, 0, 0, 2'b00, 0, resp);
    chk("b2b_first_awvalid", aw_val_seen, 4'b0001);
    chk("b2b_first_bresp", resp, 2'b00);
    chk("b2b_first_no_stray", mon_viol, 0);
    do_write(32'h0000_3100, 32'h3030_3030, 4'hF, 4'b1000, 0, 0, 2'b01, 0, resp);
    chk("b2b_second_awvalid", aw_val_seen, 4'b1000);
    chk("b2b_second_wdata", w_data_seen, 32'h3030_3030);
    chk("b2b_second_bresp", resp, 2'b01);
    chk("b2b_second_no_stray", mon_viol, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axil_wr_router.md
Name: axil_wr_router

Overview:
- Single-master to M-slave AXI-Lite write-channel router. It sits between the master-side AW/W/B ports and the M slave ports.
- It captures the write address and drives it into the address decoder (combinational; returns slave_id/decerr).
- It routes AW and W to the selected slave and returns that slave's B response.
- Unmapped writes are terminated locally with DECERR. One outstanding write at a time.

Parameters:
- M, 4, number of slave ports.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, write data width; strobe width is DATA_WIDTH/8.
- SLAVE_ID_W, (M>1)?$clog2(M):1, width of decoder slave index.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_awaddr  in  ADDR_WIDTH  master write address.
- s_awprot  in  3  master protection bits.
- s_awvalid  in  1 / s_awready  out  1  master AW handshake.
- s_wdata  in  DATA_WIDTH / s_wstrb  in  DATA_WIDTH/8  master write data/strobe.
- s_wvalid  in  1 / s_wready  out  1  master W handshake.
- s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1  master B channel.
- dec_addr  out  ADDR_WIDTH  latched address to decoder.
- dec_slave_id  in  SLAVE_ID_W / dec_decerr  in  1  decoder result.
- m_awaddr  out  ADDR_WIDTH / m_awprot  out  3  broadcast to all slaves.
- m_awvalid  out  M / m_awready  in  M  per-slave AW handshake, one-hot.
- m_wdata  out  DATA_WIDTH / m_wstrb  out  DATA_WIDTH/8  broadcast.
- m_wvalid  out  M / m_wready  in  M  per-slave W handshake, one-hot.
- m_bresp  in  2*M  packed; slave i at [2i+1:2i].
- m_bvalid  in  M / m_bready  out  M  per-slave B handshake, one-hot.

Behaviour:
- Reset values:
  - State = IDLE.
  - s_awready=1; s_wready=0; s_bvalid=0; s_bresp=0.
  - All m_*valid and m_bready = 0.
  - dec_addr, m_awaddr, m_awprot, m_wdata, m_wstrb = 0.
  - Latched slave index = 0.
- The AXI rule holds on every output channel: once VALID is high, payload is stable until READY.
- IDLE:
  - s_awready=1.
  - On s_awvalid&s_awready: latch s_awaddr/s_awprot into dec_addr/m_awaddr/m_awprot; go to DECODE.
  - W is never accepted in IDLE.
- DECODE (one cycle):
  - Register dec_slave_id and dec_decerr.
  - decerr=1 goes to ERR_W; otherwise go to ROUTE.
  - Fixed AW-to-slave latency: AWVALID reaches the slave 2 cycles after the master AW handshake.
- ROUTE:
  - m_awvalid[sel]=1 until m_awready[sel]; set flag aw_done.
  - s_wready = m_wready[sel] & !w_done; m_wvalid[sel] = s_wvalid & !w_done. W passes through combinationally with m_wdata=s_wdata.
  - On the W handshake, set w_done.
  - AW and W complete in either order or in the same cycle.
  - When aw_done&w_done, clear both flags and go to WAIT_B.
- WAIT_B:
  - m_bready[sel]=1.
  - On m_bvalid[sel]: register s_bresp = m_bresp[sel]; go to RESP.
  - A B seen before WAIT_B is not accepted (m_bready low).
- ERR_W:
  - s_wready=1; no slave port is driven.
  - On s_wvalid: discard the beat, set s_bresp=2'b11; go to RESP.
- RESP:
  - s_bvalid=1 until s_bready, then go to IDLE; s_awready rises the next cycle.
  - Minimum turnaround is 1 cycle in IDLE between transactions.
- Non-selected slaves never see VALID/READY asserted.
- sel is held constant from DECODE through RESP.
- Reset mid-transaction: all state is abandoned immediately and outputs return to reset values asynchronously. No response is issued for the aborted write.

Optional Feature:
- Macro AXIL_WR_DECERR_CNT_EN.
- When defined:
  - Adds output port decerr_count [15:0]: a saturating count of writes completed through ERR_W.
  - It increments in the cycle the ERR_W→RESP transition occurs, holds at 16'hFFFF, and resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Write to 0x0000_2004, data 0xDEAD_BEEF, strb 0xF, slave 2 readies immediately, bresp 2'b00:
  - m_awvalid=4'b0100 two cycles after the AW handshake.
  - Slave 2 sees 0xDEAD_BEEF.
  - Master sees bresp 2'b00.
- Write to 0x0000_5000 (unmapped):
  - No m_awvalid/m_wvalid asserted.
  - W is accepted and s_bresp=2'b11.
  - With the macro enabled, decerr_count goes 0→1.
- Slave 1 (0x0000_1000): W handshake occurs 3 cycles before m_awready[1], then slave B=2'b10 is delayed 5 cycles:
  - Master receives 2'b10.
  - s_wready pulses exactly once.
- s_bready held low 4 cycles after s_bvalid:
  - s_bvalid and s_bresp stay stable.
  - s_awready stays 0 until 1 cycle after the B handshake.
- rst asserted while in WAIT_B for slave 3:
  - Outputs go to reset values within the same cycle.
  - The next write to slave 0 completes normally with 2'b00.
- Back-to-back writes to slaves 0 then 3:
  - Each m_awvalid is one-hot to the correct slave.
  - No overlap; 2 responses are returned in order.
